// File: rtl/dump_pkg.sv
// Shared constants and state encoding for the debug dump sequencer.
// Byte counts come from the latch widths, rounded up to whole bytes.
package dump_pkg;

    localparam int DEF_NB_DATA     = 8;
    localparam int DEF_NB_IF_ID    = 64;
    localparam int DEF_NB_ID_EX    = 139;
    localparam int DEF_NB_EX_MEM   = 76;
    localparam int DEF_NB_MEM_WB   = 71;
    localparam int DEF_N_REGS      = 32;
    localparam int DEF_N_MEM_WORDS = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SNAP,
        ST_LATCH_TX,
        ST_LATCH_WAIT,
        ST_REG_RD,
        ST_REG_TX,
        ST_REG_WAIT,
        ST_MEM_RD,
        ST_MEM_TX,
        ST_MEM_WAIT,
        ST_FIN
    } dump_state_t;

    function automatic int bytes_of(input int nb);
        return (nb + 7) / 8;
    endfunction

    localparam int IF_ID_BYTES  = bytes_of(DEF_NB_IF_ID);
    localparam int ID_EX_BYTES  = bytes_of(DEF_NB_ID_EX);
    localparam int EX_MEM_BYTES = bytes_of(DEF_NB_EX_MEM);
    localparam int MEM_WB_BYTES = bytes_of(DEF_NB_MEM_WB);
    localparam int LATCH_BYTES  = IF_ID_BYTES + ID_EX_BYTES + EX_MEM_BYTES + MEM_WB_BYTES;
    localparam int REG_OFFSET   = LATCH_BYTES;
    localparam int MEM_OFFSET   = REG_OFFSET + 4 * DEF_N_REGS;
    localparam int TOTAL_BYTES  = MEM_OFFSET + 4 * DEF_N_MEM_WORDS;

endpackage

// File: rtl/uart_byte_sender.sv
// Launches one byte on the UART TX and holds it until the transmitter reports done.
// A done seen in the same cycle as the start pulse cannot belong to this byte and is ignored.
module uart_byte_sender #(
    parameter int NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_send,
    input  logic [NB_DATA-1:0] i_byte,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_ready
);

    logic waiting;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            waiting    <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            if (i_send && !waiting) begin
                o_tx_data  <= i_byte;
                o_tx_start <= 1'b1;
                waiting    <= 1'b1;
            end else if (waiting && !o_tx_start && i_tx_done) begin
                waiting <= 1'b0;
            end
        end
    end

    assign o_ready = !waiting;

endmodule

// File: rtl/debug_dump_sequencer.sv
// Serialises pipeline latches, register file and data memory over the UART TX.
// Latches are snapshotted once; words are read one at a time and sent MSB byte first.
module debug_dump_sequencer
    import dump_pkg::*;
#(
    parameter int NB_DATA     = DEF_NB_DATA,
    parameter int NB_IF_ID    = DEF_NB_IF_ID,
    parameter int NB_ID_EX    = DEF_NB_ID_EX,
    parameter int NB_EX_MEM   = DEF_NB_EX_MEM,
    parameter int NB_MEM_WB   = DEF_NB_MEM_WB,
    parameter int N_REGS      = DEF_N_REGS,
    parameter int N_MEM_WORDS = DEF_N_MEM_WORDS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_tx_done,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic [4:0]           o_r_addr_registers,
    input  logic [31:0]          i_r_data_registers,
    output logic [4:0]           o_r_addr_data_mem,
    input  logic [31:0]          i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int W_IF    = 8 * bytes_of(NB_IF_ID);
    localparam int W_IDEX  = 8 * bytes_of(NB_ID_EX);
    localparam int W_EXMEM = 8 * bytes_of(NB_EX_MEM);
    localparam int W_MEMWB = 8 * bytes_of(NB_MEM_WB);
    localparam int SNAP_W  = W_IF + W_IDEX + W_EXMEM + W_MEMWB;
    localparam int LAT_B   = SNAP_W / 8;

    dump_state_t state, next_state;

    logic [SNAP_W-1:0]  snap;
    logic [31:0]        word;
    logic [7:0]         lat_cnt;
    logic [1:0]         sub_cnt;
    logic [4:0]         idx;
    logic               send;
    logic [NB_DATA-1:0] tx_byte;
    logic               ready;
    logic               reg_phase;
    logic               mem_phase;
    logic [31:0]        word_src;

    assign reg_phase = (state == ST_REG_RD) || (state == ST_REG_TX) || (state == ST_REG_WAIT);
    assign mem_phase = (state == ST_MEM_RD) || (state == ST_MEM_TX) || (state == ST_MEM_WAIT);

    // The first byte of a word comes straight from the read port; later bytes from the shifted copy.
    assign word_src = (sub_cnt != 2'd0) ? word
                    : (reg_phase ? i_r_data_registers : i_r_data_data_mem);

    assign o_r_addr_registers = reg_phase ? idx : 5'd0;
    assign o_r_addr_data_mem  = mem_phase ? idx : 5'd0;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        send       = 1'b0;
        tx_byte    = '0;
        o_busy     = (state != ST_IDLE);
        o_done     = 1'b0;
        case (state)
            ST_IDLE:       if (i_start) next_state = ST_SNAP;
            ST_SNAP:       next_state = ST_LATCH_TX;
            ST_LATCH_TX: begin
                send       = 1'b1;
                tx_byte    = NB_DATA'(snap[SNAP_W-1 -: 8]);
                next_state = ST_LATCH_WAIT;
            end
            ST_LATCH_WAIT: if (ready) next_state = (lat_cnt == 8'(LAT_B - 1)) ? ST_REG_RD : ST_LATCH_TX;
            ST_REG_RD:     next_state = ST_REG_TX;
            ST_REG_TX: begin
                send       = 1'b1;
                tx_byte    = NB_DATA'(word_src[31:24]);
                next_state = ST_REG_WAIT;
            end
            ST_REG_WAIT: begin
                if (ready) begin
                    if (sub_cnt != 2'd3)              next_state = ST_REG_TX;
                    else if (idx == 5'(N_REGS - 1))   next_state = ST_MEM_RD;
                    else                              next_state = ST_REG_RD;
                end
            end
            ST_MEM_RD:     next_state = ST_MEM_TX;
            ST_MEM_TX: begin
                send       = 1'b1;
                tx_byte    = NB_DATA'(word_src[31:24]);
                next_state = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (ready) begin
                    if (sub_cnt != 2'd3)                 next_state = ST_MEM_TX;
                    else if (idx == 5'(N_MEM_WORDS - 1)) next_state = ST_FIN;
                    else                                 next_state = ST_MEM_RD;
                end
            end
            ST_FIN: begin
                o_done     = 1'b1;
                next_state = ST_IDLE;
            end
            default:       next_state = ST_IDLE;
        endcase
    end

    // Snapshot and word buffers shift left as bytes go out, so the MSB byte is always next.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            snap    <= '0;
            word    <= '0;
            lat_cnt <= '0;
            sub_cnt <= '0;
            idx     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lat_cnt <= '0;
                    sub_cnt <= '0;
                    idx     <= '0;
                end
                ST_SNAP: snap <= {W_IF'(i_IF_ID), W_IDEX'(i_ID_EX), W_EXMEM'(i_EX_MEM), W_MEMWB'(i_MEM_WB)};
                ST_LATCH_TX: snap <= snap << 8;
                ST_LATCH_WAIT: if (ready) lat_cnt <= lat_cnt + 8'd1;
                ST_REG_TX, ST_MEM_TX: word <= {word_src[23:0], 8'h00};
                ST_REG_WAIT, ST_MEM_WAIT: begin
                    if (ready) begin
                        sub_cnt <= sub_cnt + 2'd1;
                        if (sub_cnt == 2'd3) begin
                            if ((reg_phase && idx == 5'(N_REGS - 1)) ||
                                (mem_phase && idx == 5'(N_MEM_WORDS - 1))) begin
                                idx <= '0;
                            end else begin
                                idx <= idx + 5'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    uart_byte_sender #(.NB_DATA(NB_DATA)) u_sender (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_send     (send),
        .i_byte     (tx_byte),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_ready    (ready)
    );

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench: a UART responder acks each byte 3 cycles after start and records it,
// register/memory models answer with 1-cycle latency.
module tb_debug_dump_sequencer;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_start = 1'b0;
    logic         i_tx_done;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic [4:0]   o_r_addr_registers;
    logic [31:0]  i_r_data_registers = '0;
    logic [4:0]   o_r_addr_data_mem;
    logic [31:0]  i_r_data_data_mem = '0;
    logic [63:0]  i_IF_ID = '0;
    logic [138:0] i_ID_EX = '0;
    logic [75:0]  i_EX_MEM = '0;
    logic [70:0]  i_MEM_WB = '0;
    logic         o_busy;
    logic         o_done;

    logic         resp_done = 1'b0;
    logic         stray_done = 1'b0;
    logic [7:0]   captured [0:511];
    int           tx_count = 0;
    int           done_count = 0;
    int           resp_cd = 0;
    int           vectors = 0;
    int           miscompares = 0;

    assign i_tx_done = resp_done | stray_done;

    always #5 i_clk = ~i_clk;

    debug_dump_sequencer dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_tx_done          (i_tx_done),
        .o_tx_data          (o_tx_data),
        .o_tx_start         (o_tx_start),
        .o_r_addr_registers (o_r_addr_registers),
        .i_r_data_registers (i_r_data_registers),
        .o_r_addr_data_mem  (o_r_addr_data_mem),
        .i_r_data_data_mem  (i_r_data_data_mem),
        .i_IF_ID            (i_IF_ID),
        .i_ID_EX            (i_ID_EX),
        .i_EX_MEM           (i_EX_MEM),
        .i_MEM_WB           (i_MEM_WB),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    // Register file holds k*0x01010101; memory word 0 is DEADBEEF, others A55A00kk.
    always @(posedge i_clk) begin
        i_r_data_registers <= {4{3'b000, o_r_addr_registers}};
        i_r_data_data_mem  <= (o_r_addr_data_mem == 5'd0) ? 32'hDEADBEEF
                                                          : {16'hA55A, 8'h00, 3'b000, o_r_addr_data_mem};
    end

    initial begin
        forever begin
            @(negedge i_clk);
            resp_done = 1'b0;
            if (!i_reset) begin
                tx_count   = 0;
                done_count = 0;
                resp_cd    = 0;
            end else begin
                if (resp_cd > 0) begin
                    resp_cd--;
                    if (resp_cd == 0) resp_done = 1'b1;
                end
                if (o_tx_start) begin
                    if (tx_count < 512) captured[tx_count] = o_tx_data;
                    tx_count++;
                    resp_cd = 3;
                end
                if (o_done) done_count++;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] if_id, input logic [138:0] id_ex,
                                 input logic [75:0] ex_mem, input logic [70:0] mem_wb);
        i_IF_ID  = if_id;
        i_ID_EX  = id_ex;
        i_EX_MEM = ex_mem;
        i_MEM_WB = mem_wb;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic waitTxCount(input int n, input string tag);
        int cyc = 0;
        while (tx_count < n && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
        end
        checkOutput(tag, 32'(tx_count >= n), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int cyc = 0;
        while (done_count == 0 && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
        end
        checkOutput(tag, 32'(done_count != 0), 32'd1);
        repeat (5) @(negedge i_clk);
    endtask

    initial begin
        logic seen;
        logic [7:0] orv;
        int cyc;

        $display("[TB] reset phase");
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_tx_data", 32'(o_tx_data), 32'h0);
        checkOutput("rst_tx_start", 32'(o_tx_start), 32'h0);
        checkOutput("rst_addr_reg", 32'(o_r_addr_registers), 32'h0);
        checkOutput("rst_addr_mem", 32'(o_r_addr_data_mem), 32'h0);
        checkOutput("rst_busy", 32'(o_busy), 32'h0);
        checkOutput("rst_done", 32'(o_done), 32'h0);
        i_reset = 1'b1;
        @(negedge i_clk);

        $display("[TB] dump 1: latch order, registers, memory, robustness");
        applyStimulus(64'h0102030405060708, '0, 76'h9_8765_4321_0FED_CBA9, 71'h7F_1122_3344_5566_7788);
        checkOutput("busy_after_start", 32'(o_busy), 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge i_clk);
            seen = o_tx_start;
        end
        checkOutput("first_tx_start", 32'(seen), 32'h1);
        i_IF_ID = '1;
        i_EX_MEM = '1;

        waitTxCount(60, "wait_byte60");
        cyc = 0;
        while (!o_tx_start && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        stray_done = 1'b1;
        @(negedge i_clk);
        stray_done = 1'b0;

        waitTxCount(120, "wait_byte120");
        cyc = 0;
        do begin
            @(negedge i_clk);
            #1;
            cyc++;
        end while (!i_tx_done && cyc < 20);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;

        waitDone("done1_seen");
        checkOutput("done1_count", 32'(done_count), 32'd1);
        checkOutput("dump1_total", 32'(tx_count), 32'd301);
        checkOutput("busy_after_fin", 32'(o_busy), 32'h0);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("ifid_b%0d", k), 32'(captured[k]), 32'(k + 1));
        orv = '0;
        for (int k = 8; k < 26; k++) orv = orv | captured[k];
        checkOutput("idex_zero", 32'(orv), 32'h0);
        checkOutput("exmem_b26", 32'(captured[26]), 32'h00);
        checkOutput("exmem_b27", 32'(captured[27]), 32'h09);
        checkOutput("exmem_b35", 32'(captured[35]), 32'hA9);
        checkOutput("memwb_b36", 32'(captured[36]), 32'h7F);
        checkOutput("memwb_b44", 32'(captured[44]), 32'h88);
        checkOutput("reg0_bytes", {captured[45], captured[46], captured[47], captured[48]}, 32'h00000000);
        checkOutput("reg1_bytes", {captured[49], captured[50], captured[51], captured[52]}, 32'h01010101);
        checkOutput("reg31_bytes", {captured[169], captured[170], captured[171], captured[172]}, 32'h1F1F1F1F);
        checkOutput("mem0_bytes", {captured[173], captured[174], captured[175], captured[176]}, 32'hDEADBEEF);
        checkOutput("mem1_bytes", {captured[177], captured[178], captured[179], captured[180]}, 32'hA55A0001);
        checkOutput("mem31_bytes", {captured[297], captured[298], captured[299], captured[300]}, 32'hA55A001F);

        $display("[TB] dump 2: reset abort at byte 100");
        applyStimulus(64'h0102030405060708, {11'h7FF, 128'h0}, '0, '0);
        waitTxCount(100, "wait_byte100");
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        repeat (40) @(negedge i_clk);
        checkOutput("abort_no_tx", 32'(tx_count), 32'd0);
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        checkOutput("abort_busy", 32'(o_busy), 32'h0);

        $display("[TB] dump 3: restart with padded ID_EX");
        applyStimulus(64'h0102030405060708, {11'h7FF, 128'h0}, '0, '0);
        waitDone("done3_seen");
        checkOutput("done3_count", 32'(done_count), 32'd1);
        checkOutput("dump3_total", 32'(tx_count), 32'd301);
        checkOutput("restart_b0", 32'(captured[0]), 32'h01);
        checkOutput("pad_idex_b8", 32'(captured[8]), 32'h07);
        checkOutput("pad_idex_b9", 32'(captured[9]), 32'hFF);
        checkOutput("pad_idex_b10", 32'(captured[10]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
